// File: rtl/regfile_bypass_sb_if.sv
// Register file / scoreboard bus.
// Groups every signal exchanged between the register file and the pipeline:
//   writeback : RegWrite, write_addr, write_data
//   decode    : read_addr1/2 -> read_data1/2, issue_valid, issue_rd
//   hazard    : rs1_busy, rs2_busy, busy_count
// master = pipeline side (drives addresses, data, enables)
// slave  = register file side (returns read data and busy status)
interface regfile_bypass_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            RegWrite;
  logic [AW-1:0]   write_addr;
  logic [XLEN-1:0] write_data;
  logic [AW-1:0]   read_addr1;
  logic [AW-1:0]   read_addr2;
  logic [XLEN-1:0] read_data1;
  logic [XLEN-1:0] read_data2;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic            rs1_busy;
  logic            rs2_busy;
  logic [AW:0]     busy_count;

  modport master (
    output RegWrite, write_addr, write_data,
    output read_addr1, read_addr2,
    output issue_valid, issue_rd,
    input  read_data1, read_data2,
    input  rs1_busy, rs2_busy, busy_count
  );

  modport slave (
    input  RegWrite, write_addr, write_data,
    input  read_addr1, read_addr2,
    input  issue_valid, issue_rd,
    output read_data1, read_data2,
    output rs1_busy, rs2_busy, busy_count
  );
endinterface

// File: rtl/regfile_bypass_sb.sv
// Parametrised integer register file with same-cycle write-to-read bypass
// and a per-register busy scoreboard.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low reset
//   bus   - regfile_bypass_sb_if.slave: write port, two combinational read
//           ports, issue reservation, per-source busy flags, busy count
// Addresses >= NREGS are invalid: they read 0, are never busy, and writes or
// issues to them are dropped. With ZERO_REG, register 0 behaves the same way.
module regfile_bypass_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                reset,
  regfile_bypass_sb_if.slave  bus
);
  localparam int AW    = (NREGS <= 4) ? 2 : $clog2(NREGS);
  localparam int NSLOT = 1 << AW;
  localparam logic [AW:0] NREGS_W = NREGS[AW:0];

  // True when the address names a real, writable register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    addr_ok = ({1'b0, a} < NREGS_W) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      busy_count_q, busy_count_d;
  logic [NSLOT-1:0] busy_pad;

  logic wr_hit, iss_hit, cnt_inc, cnt_dec;

  // State updates need no reset gating: the flops are held while reset is low.
  assign wr_hit   = bus.RegWrite && addr_ok(bus.write_addr);
  assign iss_hit  = bus.issue_valid && addr_ok(bus.issue_rd);
  // Zero-extended copy so any AW-bit address can index it safely.
  assign busy_pad = NSLOT'(busy_q);

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = (wr_hit && bus.write_addr == AW'(i)) ? bus.write_data : regs_q[i];
      // Issue is applied after the clear so a same-cycle set wins.
      busy_d[i] = (busy_q[i] && !(wr_hit && bus.write_addr == AW'(i))) ||
                  (iss_hit && bus.issue_rd == AW'(i));
    end
  end

  // Count tracks popcount(busy_d) incrementally: a re-issue of a busy
  // register adds nothing, a write to a free register removes nothing, and a
  // write that is overridden by a same-register issue removes nothing.
  always_comb begin
    cnt_inc      = iss_hit && !busy_pad[bus.issue_rd];
    cnt_dec      = wr_hit && busy_pad[bus.write_addr] &&
                   !(iss_hit && bus.issue_rd == bus.write_addr);
    busy_count_d = busy_count_q + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  // Two identical read ports. A forwarded write also hides the busy bit,
  // since the producer's result is available this cycle.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [AW-1:0]   ra;
    logic            fwd;
    logic [XLEN-1:0] data;
    logic            busy;

    assign ra = (gi == 0) ? bus.read_addr1 : bus.read_addr2;

    always_comb begin
      fwd  = (BYPASS != 0) && wr_hit && (bus.write_addr == ra);
      data = '0;
      busy = 1'b0;
      if (reset && addr_ok(ra)) begin
        data = fwd ? bus.write_data : regs_q[ra];
        busy = busy_pad[ra] && !fwd;
      end
    end
  end

  assign bus.read_data1 = g_rd[0].data;
  assign bus.read_data2 = g_rd[1].data;
  assign bus.rs1_busy   = g_rd[0].busy;
  assign bus.rs2_busy   = g_rd[1].busy;
  assign bus.busy_count = busy_count_q;
endmodule
